// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the block-RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 4;
  localparam int MAX_NREQ   = 4;

  // Bits needed to hold values 0..n-1 (at least 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Requester id width, sized for the largest supported requester count.
  localparam int ID_W = clog2(MAX_NREQ);

  // One RAM command as seen at the RAM pins.
  typedef struct packed {
    logic                  en;
    logic                  we;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } ram_cmd_t;

  // Tag travelling alongside an outstanding read.
  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } rd_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from a rotating priority pointer.
// Latency: gnt is combinational from req and ptr; ptr updates on the grant edge.
// Backpressure: requesters hold req until granted; gnt forced low during reset.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic          w_found;

  // Search from ptr upwards with wrap; first requester found wins.
  always_comb begin
    gnt       = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    if (reset) begin
      for (int j = 0; j < NREQ; j++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!w_found && req[i] && (((int'(r_ptr) + j) % NREQ) == i)) begin
            w_found   = 1'b1;
            gnt[i]    = 1'b1;
            w_ptr_nxt = PW'((i + 1) % NREQ);
          end
        end
      end
    end
  end

  // Pointer moves just past the granted requester; holds when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM among NREQ requesters, one access per cycle, round-robin.
// Latency: grant at T -> RAM command at T+1 -> rvalid/rdata at T+1+READ_LATENCY.
// Backpressure: req/gnt handshake; an ungranted requester holds req, we, addr and wdata.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          we,
  input  logic [NREQ*ADDR_W-1:0]   addr,
  input  logic [NREQ*DATA_W-1:0]   wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [ADDR_W-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_dout
);

  logic              w_any;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_din;
  logic [ID_W-1:0]   w_sel_id;
  rd_tag_t           w_last_tag;

  logic              r_en;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_din;
  logic [NREQ-1:0]   r_rvalid;
  rd_tag_t           r_tag [READ_LATENCY];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .gnt   (gnt)
  );

  assign w_any = |gnt;

  // Select the granted requester's command fields (gnt is one-hot).
  always_comb begin
    w_sel_we   = 1'b0;
    w_sel_addr = '0;
    w_sel_din  = '0;
    w_sel_id   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        w_sel_we   = we[i];
        w_sel_addr = addr[i*ADDR_W +: ADDR_W];
        w_sel_din  = wdata[i*DATA_W +: DATA_W];
        w_sel_id   = ID_W'(i);
      end
    end
  end

  // Issue register: pulse enable on a grant; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_we   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_any) begin
      r_en   <= 1'b1;
      r_we   <= w_sel_we;
      r_addr <= w_sel_addr;
      r_din  <= w_sel_din;
    end else begin
      r_en   <= 1'b0;
      r_we   <= 1'b0;
    end
  end

  // Read-tag shift pipeline, stage 0 aligned with the command at the RAM pins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < READ_LATENCY; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_any && !w_sel_we, id: w_sel_id};
      for (int i = 1; i < READ_LATENCY; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign w_last_tag = r_tag[READ_LATENCY-1];

  // Decode the oldest tag into a one-cycle per-requester rvalid pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rvalid <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        r_rvalid[i] <= w_last_tag.valid && (w_last_tag.id == ID_W'(i));
      end
    end
  end

  assign ram_en   = r_en;
  assign ram_we   = r_we;
  assign ram_addr = r_addr;
  assign ram_din  = r_din;
  assign rvalid   = r_rvalid;
  assign rdata    = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: model expects command at T+1, response at T+2 after a grant at T.
// Backpressure: stimulus holds each request stable until the model says it was granted.
module tb_ram_arbiter;

  localparam int NREQ = 2;

  logic            clk;
  logic            reset;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] we;
  logic [7:0]      addr;
  logic [7:0]      wdata;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] rvalid;
  logic [3:0]      rdata;
  logic            ram_en;
  logic            ram_we;
  logic [3:0]      ram_addr;
  logic [3:0]      ram_din;
  logic [3:0]      ram_dout;

  ram_arbiter #(.NREQ(NREQ), .ADDR_W(4), .DATA_W(4), .READ_LATENCY(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .we       (we),
    .addr     (addr),
    .wdata    (wdata),
    .gnt      (gnt),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM driven by the DUT.
  logic [3:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      else        ram_dout <= ram_mem[ram_addr];
    end
  end

  // Reference model state.
  logic [3:0] mdl_mem [16];
  int         m_ptr;
  logic       m_en, m_we;
  logic [3:0] m_addr, m_din;
  logic [1:0] m_rv;
  logic [3:0] m_rdata;
  logic       p_vld;
  int         p_id;
  logic [3:0] p_data;
  int         last_g;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs, compare against model, then advance the model past the edge.
  task automatic step(input logic [1:0] r, input logic [1:0] w,
                      input logic [7:0] a, input logic [7:0] d, input logic rst);
    int g;
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d; reset = rst;
    #1;
    g = -1;
    if (rst) begin
      for (int j = 0; j < NREQ; j++) begin
        int k;
        k = (m_ptr + j) % NREQ;
        if (g < 0 && r[k]) g = k;
      end
    end
    chk("gnt",      gnt,      (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("ram_en",   ram_en,   m_en);
    chk("ram_we",   ram_we,   m_we);
    chk("ram_addr", ram_addr, m_addr);
    chk("ram_din",  ram_din,  m_din);
    chk("rvalid",   rvalid,   m_rv);
    if (m_rv != 2'b00) chk("rdata", rdata, m_rdata);
    last_g = g;
    if (!rst) begin
      m_ptr = 0; m_en = 0; m_we = 0; m_addr = 0; m_din = 0;
      m_rv = 0; p_vld = 0;
    end else begin
      m_rv    = p_vld ? (2'b01 << p_id) : 2'b00;
      m_rdata = p_data;
      p_vld   = 0;
      if (g >= 0) begin
        m_en   = 1'b1;
        m_we   = w[g];
        m_addr = a[g*4 +: 4];
        m_din  = d[g*4 +: 4];
        if (w[g]) begin
          mdl_mem[a[g*4 +: 4]] = d[g*4 +: 4];
        end else begin
          p_vld  = 1'b1;
          p_id   = g;
          p_data = mdl_mem[a[g*4 +: 4]];
        end
        m_ptr = (g + 1) % NREQ;
      end else begin
        m_en = 1'b0;
        m_we = 1'b0;
      end
    end
  endtask

  logic       cur_req [NREQ];
  logic       cur_we  [NREQ];
  logic [3:0] cur_addr[NREQ];
  logic [3:0] cur_wd  [NREQ];
  logic       rnd_rst;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = 4'((i * 7 + 3) & 15);
      mdl_mem[i] = 4'((i * 7 + 3) & 15);
    end
    ram_mem[5] = 4'hA;
    mdl_mem[5] = 4'hA;
    m_ptr = 0; m_en = 0; m_we = 0; m_addr = 0; m_din = 0;
    m_rv = 0; m_rdata = 0; p_vld = 0; p_id = 0; p_data = 0; last_g = -1;
    req = 0; we = 0; addr = 0; wdata = 0; reset = 1'b0; ram_dout = 0;
    repeat (2) @(posedge clk);

    // Reset held with both requesting, then first grant goes to requester 0.
    step(2'b11, 2'b00, 8'h21, 8'h00, 1'b0);
    step(2'b11, 2'b00, 8'h21, 8'h00, 1'b0);
    // Contention: both hold req; grants alternate.
    repeat (6) step(2'b11, 2'b00, 8'h21, 8'h00, 1'b1);
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Single read by requester 1 of addr 5.
    step(2'b10, 2'b00, 8'h50, 8'h00, 1'b1);
    repeat (2) step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Read-after-write: req 0 writes 7 to addr 3, req 1 reads addr 3 next cycle.
    step(2'b01, 2'b01, 8'h03, 8'h07, 1'b1);
    step(2'b10, 2'b00, 8'h30, 8'h00, 1'b1);
    repeat (2) step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Back-to-back reads by requester 0.
    step(2'b01, 2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b01, 2'b00, 8'h01, 8'h00, 1'b1);
    step(2'b01, 2'b00, 8'h02, 8'h00, 1'b1);
    repeat (2) step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Reset while a read is in flight; pointer must return to 0.
    step(2'b01, 2'b00, 8'h05, 8'h00, 1'b1);
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);
    step(2'b11, 2'b00, 8'h44, 8'h00, 1'b1);
    repeat (2) step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    // Random traffic; each request is held until granted.
    for (int i = 0; i < NREQ; i++) cur_req[i] = 1'b0;
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!cur_req[i] || last_g == i) begin
          cur_req[i]  = ($urandom_range(0, 3) != 0);
          cur_we[i]   = 1'($urandom_range(0, 1));
          cur_addr[i] = 4'($urandom_range(0, 7));
          cur_wd[i]   = 4'($urandom_range(0, 15));
        end
      end
      rnd_rst = ($urandom_range(0, 49) != 0);
      step({cur_req[1], cur_req[0]}, {cur_we[1], cur_we[0]},
           {cur_addr[1], cur_addr[0]}, {cur_wd[1], cur_wd[0]}, rnd_rst);
    end
    repeat (3) step(2'b00, 2'b00, 8'h00, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

- Shares the single-port 16x4 block RAM between `NREQ` requesters, such as CPU data port and program loader, with one access per cycle.
- Arbitration is round-robin with a per-requester req/gnt handshake.
- RAM command signals are registered; read data is broadcast and tagged with a per-requester `rvalid` pulse.
- Sits between the requesters and the RAM wrapper. It is the only driver of the RAM's enable, write-enable, address and data-in.

## Interface
- `NREQ`, 2, number of requesters (2..4)
- `ADDR_W`, 4, RAM address width
- `DATA_W`, 4, RAM data width
- `READ_LATENCY`, 1, cycles from RAM command registered at RAM pins to valid `ram_dout`
- `clk  in  1  single clock; all logic on rising edge`
- `reset  in  1  synchronous, active-low; reset==0 resets the block at the next rising edge`
- `req  in  NREQ  request, held until granted`
- `we  in  NREQ  per-requester write (1) / read (0)`
- `addr  in  NREQ*ADDR_W  per-requester address, flattened, requester i at [i*ADDR_W +: ADDR_W]`
- `wdata  in  NREQ*DATA_W  per-requester write data, flattened likewise`
- `gnt  out  NREQ  one-hot, combinational; request accepted this cycle`
- `rvalid  out  NREQ  one-hot, registered; `rdata` valid for that requester`
- `rdata  out  DATA_W  read data, broadcast (= `ram_dout`)`
- `ram_en  out  1  registered RAM enable`
- `ram_we  out  1  registered RAM write enable`
- `ram_addr  out  ADDR_W  registered RAM address`
- `ram_din  out  DATA_W  registered RAM write data`
- `ram_dout  in  DATA_W  RAM read data`

## Operation
- **Grant:**
  - Each cycle, with reset==1, `gnt` selects at most one requester with `req`=1.
  - The search starts at priority pointer `ptr` and wraps modulo `NREQ`.
  - With no `req`, `gnt`=0.
- **Pointer:** on a grant to requester k, `ptr` <= (k+1) mod `NREQ`. Otherwise `ptr` holds.
- **Handshake:**
  - The transfer occurs when `req[i]` && `gnt[i]`.
  - The requester keeps `we`/`addr`/`wdata` stable while `req`=1 and not granted.
  - It may drop `req` or present a new request on the next cycle.
- **Issue register:**
  - On a grant, next cycle `ram_en`=1, with `ram_we`/`ram_addr`/`ram_din` from the granted requester.
  - Otherwise `ram_en`=0, `ram_we`=0, and address/data hold.
- **Read tracking:**
  - Every issued read pushes (valid, requester id) into a shift pipeline of depth `READ_LATENCY`.
  - At the output, `rvalid[id]`=1 for exactly one cycle.
  - Writes produce no response.
- **Ordering:**
  - Commands reach the RAM in grant order.
  - A read granted the cycle after a write to the same address returns the new data.
  - Simultaneous read and write requests from different requesters are serialized by round-robin order only.
- **Reset (reset==0):**
  - `ptr`=0, `gnt`=0, `ram_en`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0.
  - The read pipeline is cleared and `rvalid`=0.
  - `rdata` follows `ram_dout` (don't-care).
- **Reset mid-operation:** in-flight reads are dropped and no `rvalid` is produced for them. The RAM sees `ram_en`=0 from the first cycle after the reset edge.

## Timing
- Grant at cycle T leads to the RAM command at T+1.
- Read data and `rvalid` arrive at T+1+`READ_LATENCY` (T+2 by default).
- Throughput is one access per cycle, with back-to-back grants to the same or different requesters.
- Fairness: a continuously requesting requester is granted within `NREQ` cycles.
- With all `NREQ` requesting every cycle, grants rotate 0,1,…,NREQ-1,0.
- `gnt` is combinational from `req` and `ptr`. All other outputs are registered.

## Structure
- Package `ram_arb_pkg` holds:
  - `ADDR_W`/`DATA_W` defaults.
  - `ram_cmd_t` struct {en, we, addr, data}.
  - `rd_tag_t` struct {valid, id}.
  - The `clog2`-based id width.
- Sub-module `rr_arbiter`: parameter `NREQ`, inputs `clk`/`reset`/`req`, output one-hot `gnt`. It owns `ptr` and its update.
- The top level holds the issue register, the read-tag pipeline and the output mux.

## Test plan
- **Reset:** reset=0 for 2 cycles with `req`=2'b11 → `gnt`=0, `ram_en`=0, `rvalid`=0. After release, the first grant goes to requester 0.
- **Single read:** requester 1 reads addr 4'h5 holding 4'hA → `gnt[1]` at T, `ram_en`=1/`ram_we`=0/`ram_addr`=5 at T+1, `rvalid`=2'b10 with `rdata`=4'hA at T+2.
- **Contention:** both requesters hold `req` for 6 cycles → grants alternate 0,1,0,1,0,1. Each request is stable until granted.
- **Read-after-write:**
  - Requester 0 writes 4'h7 to addr 4'h3.
  - Requester 1 reads addr 4'h3 on the next grant.
  - Expected: `rvalid[1]` with `rdata`=4'h7.
- **Back-to-back reads:** requester 0 reads addr 0,1,2 on consecutive cycles → three consecutive `rvalid[0]` pulses carrying mem[0],mem[1],mem[2] in order.
- **Mid-flight reset:** grant a read at T, reset=0 at T+1 → no `rvalid` at T+2. `ram_en`=0 while in reset. After release, `ptr`=0.
